// File: rtl/calc1_pkg.sv
// calc1 shared types: command codes, response codes and the request-driver state encoding.
package calc1_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_OK   = 2'd1,
    RSP_OVF  = 2'd2,
    RSP_INV  = 2'd3
  } rsp_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND1     = 3'd1,
    ST_SEND2     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/calc1_req_driver_if.sv
// Transaction, calc1 port and result signals of one request driver.
// The master modport is the driver; slave is the environment around it.
interface calc1_req_driver_if #(
  parameter int unsigned LAT_W = 8
);
  logic             txn_valid;
  logic             txn_ready;
  logic [3:0]       txn_cmd;
  logic [31:0]      txn_op1;
  logic [31:0]      txn_op2;
  logic [3:0]       req_cmd_out;
  logic [31:0]      req_data_out;
  logic [1:0]       out_resp;
  logic [31:0]      out_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_code;
  logic [31:0]      rsp_data;
  logic [LAT_W-1:0] rsp_latency;
  logic             rsp_timeout;
  logic             spurious_resp;

  modport master (
    input  txn_valid, txn_cmd, txn_op1, txn_op2, out_resp, out_data, rsp_ready,
    output txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data,
           rsp_latency, rsp_timeout, spurious_resp
  );

  modport slave (
    output txn_valid, txn_cmd, txn_op1, txn_op2, out_resp, out_data, rsp_ready,
    input  txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data,
           rsp_latency, rsp_timeout, spurious_resp
  );
endinterface

// File: rtl/calc1_lat_ctr.sv
// Saturating response-latency counter; the expiry compare exists only with CALC1_REQ_TIMEOUT_EN.
// Expiry can only fire if TIMEOUT_CYCLES <= 2**LAT_W, since the count itself saturates.
module calc1_lat_ctr #(
  parameter int unsigned LAT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [LAT_W-1:0] o_count,
  output logic             o_expire
);
  logic [LAT_W-1:0] r_count;

  always_ff @(posedge c_clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + LAT_W'(1);
    end
  end

  assign o_count = r_count;

`ifdef CALC1_REQ_TIMEOUT_EN
  // Fires in the last allowed wait cycle, so a response in that same cycle still wins.
  logic [32:0] w_count_plus1;
  assign w_count_plus1 = 33'(r_count) + 33'd1;
  assign o_expire      = i_inc && (w_count_plus1 >= 33'(TIMEOUT_CYCLES));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign o_expire         = 1'b0;
`endif

endmodule

// File: rtl/calc1_req_driver.sv
// calc1_req_driver: drives one calc1 request port per transaction and returns code/data/latency.
// Define CALC1_REQ_TIMEOUT_EN to abort WAIT_RESP after TIMEOUT_CYCLES silent cycles.
module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int unsigned LAT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                c_clk,
  input logic                reset,
  calc1_req_driver_if.master bus
);
  state_e           r_state;
  state_e           w_state_next;
  logic [31:0]      r_op2;
  logic             r_txn_ready;
  logic [3:0]       r_req_cmd;
  logic [31:0]      r_req_data;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_code;
  logic [31:0]      r_rsp_data;
  logic [LAT_W-1:0] r_rsp_lat;
  logic             r_spurious;

  logic [3:0]       w_req_cmd_next;
  logic [31:0]      w_req_data_next;
  logic [1:0]       w_rsp_code_next;
  logic [31:0]      w_rsp_data_next;
  logic [LAT_W-1:0] w_rsp_lat_next;
  logic             w_spurious_next;

  logic             w_in_wait;
  logic             w_resp_hit;
  logic             w_expire;
  logic [LAT_W-1:0] w_lat_count;

  assign w_in_wait  = (r_state == ST_WAIT_RESP);
  assign w_resp_hit = w_in_wait && (bus.out_resp != 2'b00);

  calc1_lat_ctr #(
    .LAT_W          (LAT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_lat_ctr (
    .c_clk    (c_clk),
    .reset    (reset),
    .i_clr    (r_state == ST_SEND2),
    .i_inc    (w_in_wait),
    .o_count  (w_lat_count),
    .o_expire (w_expire)
  );

`ifdef CALC1_REQ_TIMEOUT_EN
  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] TO_LAT  =
    (64'(TIMEOUT_CYCLES) > 64'(LAT_MAX)) ? LAT_MAX : LAT_W'(TIMEOUT_CYCLES);
  logic r_rsp_timeout;
  logic w_rsp_timeout_next;
`endif

  // State and output registers; outputs are registered from the next-state view.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_op2         <= '0;
      r_txn_ready   <= 1'b1;
      r_req_cmd     <= '0;
      r_req_data    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_code    <= '0;
      r_rsp_data    <= '0;
      r_rsp_lat     <= '0;
      r_spurious    <= 1'b0;
`ifdef CALC1_REQ_TIMEOUT_EN
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_txn_ready   <= (w_state_next == ST_IDLE);
      r_req_cmd     <= w_req_cmd_next;
      r_req_data    <= w_req_data_next;
      r_rsp_valid   <= (w_state_next == ST_DONE);
      r_rsp_code    <= w_rsp_code_next;
      r_rsp_data    <= w_rsp_data_next;
      r_rsp_lat     <= w_rsp_lat_next;
      r_spurious    <= w_spurious_next;
`ifdef CALC1_REQ_TIMEOUT_EN
      r_rsp_timeout <= w_rsp_timeout_next;
`endif
      if ((r_state == ST_IDLE) && bus.txn_valid) begin
        r_op2 <= bus.txn_op2;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (bus.txn_valid) w_state_next = ST_SEND1;
      ST_SEND1:     w_state_next = ST_SEND2;
      ST_SEND2:     w_state_next = ST_WAIT_RESP;
      ST_WAIT_RESP: if (w_resp_hit || w_expire) w_state_next = ST_DONE;
      ST_DONE:      if (bus.rsp_ready) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_cmd_next     = '0;
    w_req_data_next    = '0;
    w_rsp_code_next    = r_rsp_code;
    w_rsp_data_next    = r_rsp_data;
    w_rsp_lat_next     = r_rsp_lat;
    w_spurious_next    = !w_in_wait && (bus.out_resp != 2'b00);
`ifdef CALC1_REQ_TIMEOUT_EN
    w_rsp_timeout_next = r_rsp_timeout;
`endif
    // SEND1 is only entered from IDLE, so the live transaction inputs are still valid here.
    unique case (w_state_next)
      ST_SEND1: begin
        w_req_cmd_next  = bus.txn_cmd;
        w_req_data_next = bus.txn_op1;
      end
      ST_SEND2: w_req_data_next = r_op2;
      default:  ;
    endcase
    if (w_resp_hit) begin
      w_rsp_code_next    = bus.out_resp;
      w_rsp_data_next    = bus.out_data;
      w_rsp_lat_next     = w_lat_count;
`ifdef CALC1_REQ_TIMEOUT_EN
      w_rsp_timeout_next = 1'b0;
    end else if (w_expire) begin
      w_rsp_code_next    = RSP_NONE;
      w_rsp_data_next    = '0;
      w_rsp_lat_next     = TO_LAT;
      w_rsp_timeout_next = 1'b1;
`endif
    end
  end

  assign bus.txn_ready     = r_txn_ready;
  assign bus.req_cmd_out   = r_req_cmd;
  assign bus.req_data_out  = r_req_data;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_code      = r_rsp_code;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_latency   = r_rsp_lat;
  assign bus.spurious_resp = r_spurious;
`ifdef CALC1_REQ_TIMEOUT_EN
  assign bus.rsp_timeout   = r_rsp_timeout;
`else
  assign bus.rsp_timeout   = 1'b0;
`endif

endmodule
